// File: rtl/sram_bus_pkg.sv
// Shared types and sizing helpers for the two-master external SRAM arbiter.
package sram_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_ACCESS = 3'd2,
        ST_DONE   = 3'd3,
        ST_TURN   = 3'd4
    } state_t;

    localparam int ADDR_W_DEF = 15;
    localparam int DATA_W_DEF = 8;

    // Width of the shared ACCESS/TURN down-counter.
    function automatic int cnt_width(input int wait_cyc, input int turn_cyc);
        int max_cyc;
        max_cyc = (wait_cyc > turn_cyc) ? wait_cyc : turn_cyc;
        return (max_cyc < 1) ? 1 : $clog2(max_cyc + 1);
    endfunction

endpackage

// File: rtl/sram_rr_arb.sv
// Two-way round-robin arbiter; the pointer moves away from whichever master was just granted.
module sram_rr_arb (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    logic       ptr_r;
    logic [1:0] gnt_s;

    // Grant decode: a lone requester wins, contention resolved by the pointer.
    always_comb begin
        gnt_s = 2'b00;
        case (req)
            2'b01:   gnt_s = 2'b01;
            2'b10:   gnt_s = 2'b10;
            2'b11:   gnt_s = ptr_r ? 2'b10 : 2'b01;
            default: gnt_s = 2'b00;
        endcase
    end

    assign gnt = gnt_s;

    // Pointer flop: after granting m0 prefer m1, and vice versa.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r <= 1'b0;
        end else if (advance && (gnt_s != 2'b00)) begin
            ptr_r <= gnt_s[0];
        end else begin
            ptr_r <= ptr_r;
        end
    end

endmodule

// File: rtl/sram_bus_arbiter.sv
// Two-master arbiter and bus-cycle sequencer for a 32Kx8 asynchronous SRAM with registered strobes.
module sram_bus_arbiter
    import sram_bus_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int WAIT_CYC = 2,
    parameter int TURN_CYC = 1
) (
    input  logic              clk,
    input  logic              sys_rst_n,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    inout  wire  [DATA_W-1:0] mem_data,
    output logic              mem_cs_n,
    output logic              mem_oe_n,
    output logic              mem_we_n
);

    localparam int CNT_W = cnt_width(WAIT_CYC, TURN_CYC);

    if (WAIT_CYC < 1) begin : g_bad_wait
        $error("sram_bus_arbiter: WAIT_CYC must be >= 1");
    end
    if (TURN_CYC < 1) begin : g_bad_turn
        $error("sram_bus_arbiter: TURN_CYC must be >= 1");
    end

    state_t             state_r, state_nxt_s;
    logic [CNT_W-1:0]   cnt_r, cnt_nxt_s;
    logic [1:0]         gnt_s;
    logic               grant_s;
    logic               sel_r;
    logic               we_lat_r;
    logic [DATA_W-1:0]  wdata_lat_r;
    logic               drv_en_r;
    logic               we_nxt_s;
    logic               cyc_nxt_s;
    logic               rd_sample_s;

    sram_rr_arb u_arb (
        .clk     (clk),
        .rst_n   (sys_rst_n),
        .req     ({m1_req, m0_req}),
        .advance (state_r == ST_IDLE),
        .gnt     (gnt_s)
    );

    assign grant_s  = (state_r == ST_IDLE) && (gnt_s != 2'b00);
    assign mem_data = drv_en_r ? wdata_lat_r : {DATA_W{1'bz}};

    // Next-state and shared counter; also the direction of the cycle about to run.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (grant_s) begin
                    state_nxt_s = ST_SETUP;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SETUP: begin
                state_nxt_s = ST_ACCESS;
                cnt_nxt_s   = CNT_W'(WAIT_CYC - 1);
            end
            ST_ACCESS: begin
                if (cnt_r == {CNT_W{1'b0}}) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    cnt_nxt_s = cnt_r - CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_TURN;
                cnt_nxt_s   = CNT_W'(TURN_CYC - 1);
            end
            ST_TURN: begin
                if (cnt_r == {CNT_W{1'b0}}) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    cnt_nxt_s = cnt_r - CNT_W'(1);
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = {CNT_W{1'b0}};
            end
        endcase
        if (grant_s) begin
            we_nxt_s = gnt_s[1] ? m1_we : m0_we;
        end else begin
            we_nxt_s = we_lat_r;
        end
        cyc_nxt_s   = (state_nxt_s == ST_SETUP) || (state_nxt_s == ST_ACCESS) ||
                      (state_nxt_s == ST_DONE);
        rd_sample_s = (state_r == ST_ACCESS) && (cnt_r == {CNT_W{1'b0}}) && !we_lat_r;
    end

    // FSM, strobes and acks are all decoded from the next state and registered.
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_r  <= ST_IDLE;
            cnt_r    <= {CNT_W{1'b0}};
            mem_cs_n <= 1'b1;
            mem_oe_n <= 1'b1;
            mem_we_n <= 1'b1;
            drv_en_r <= 1'b0;
            m0_ack   <= 1'b0;
            m1_ack   <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            cnt_r    <= cnt_nxt_s;
            mem_cs_n <= !cyc_nxt_s;
            mem_oe_n <= !((state_nxt_s == ST_ACCESS) && !we_nxt_s);
            mem_we_n <= !((state_nxt_s == ST_ACCESS) && we_nxt_s);
            drv_en_r <= cyc_nxt_s && we_nxt_s;
            m0_ack   <= (state_nxt_s == ST_DONE) && !sel_r;
            m1_ack   <= (state_nxt_s == ST_DONE) && sel_r;
        end
    end

    // Request latches: captured only at grant so later master changes are ignored.
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sel_r       <= 1'b0;
            we_lat_r    <= 1'b0;
            mem_addr    <= {ADDR_W{1'b0}};
            wdata_lat_r <= {DATA_W{1'b0}};
        end else if (grant_s) begin
            sel_r       <= gnt_s[1];
            we_lat_r    <= gnt_s[1] ? m1_we    : m0_we;
            mem_addr    <= gnt_s[1] ? m1_addr  : m0_addr;
            wdata_lat_r <= gnt_s[1] ? m1_wdata : m0_wdata;
        end else begin
            sel_r       <= sel_r;
            we_lat_r    <= we_lat_r;
            mem_addr    <= mem_addr;
            wdata_lat_r <= wdata_lat_r;
        end
    end

    // Read capture at the edge closing the last ACCESS cycle, into the granted master only.
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            m0_rdata <= {DATA_W{1'b0}};
            m1_rdata <= {DATA_W{1'b0}};
        end else if (rd_sample_s && !sel_r) begin
            m0_rdata <= mem_data;
            m1_rdata <= m1_rdata;
        end else if (rd_sample_s && sel_r) begin
            m0_rdata <= m0_rdata;
            m1_rdata <= mem_data;
        end else begin
            m0_rdata <= m0_rdata;
            m1_rdata <= m1_rdata;
        end
    end

endmodule
